// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM encoding and width helper for uart_tx_arbiter
// Contents:
//   BYTE_W     byte width carried to the transmitter
//   state_t    FSM state type, with ST_* encodings
//   rr_w(n)    width of a requester index for n requesters (at least 1)
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CAPTURE   = 3'd1;
    localparam logic [2:0] ST_STROBE    = 3'd2;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
    localparam logic [2:0] ST_SEND      = 3'd4;
    localparam logic [2:0] ST_HOLD      = 3'd5;

    function automatic int rr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and transmitter signals shared by uart_tx_arbiter
// Signals:
//   req_valid/req_data/req_last  requester byte offers (byte i at [8i+7:8i])
//   req_ready                    one-hot accept pulse back to the requesters
//   tx_wr/tx_data/tx_busy        txuart write strobe, frame byte, busy flag
//   grant_id/locked              current or last grant, packet-in-progress flag
// Modports: slave = arbiter side, master = requester/transmitter side.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NREQ = 4
) ();

    logic [NREQ-1:0]        req_valid;
    logic [BYTE_W*NREQ-1:0] req_data;
    logic [NREQ-1:0]        req_last;
    logic [NREQ-1:0]        req_ready;
    logic                   tx_wr;
    logic [BYTE_W-1:0]      tx_data;
    logic                   tx_busy;
    logic [rr_w(NREQ)-1:0]  grant_id;
    logic                   locked;

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_wr, tx_data, grant_id, locked
    );

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_wr, tx_data, grant_id, locked
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin priority encoder
// Ports:
//   req   request vector
//   last  index of the previous winner; search starts at last+1 (mod NREQ)
//   any   at least one request is present
//   idx   first requesting index in round-robin order (last when none)
module rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int RW  = rr_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [RW-1:0]   last,
    output logic            any,
    output logic [RW-1:0]   idx
);

    logic [RW-1:0] cand;

    // Walk from the farthest offset back to the nearest so the nearest
    // requester after 'last' is the final (winning) assignment.
    always_comb begin
        any  = |req;
        idx  = last;
        cand = last;
        for (int k = NREQ; k >= 1; k--) begin
            cand = RW'((int'(last) + k) % NREQ);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one txuart between NREQ byte producers
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    uart_tx_arbiter_if.slave: requester handshakes, txuart strobe/data/busy,
//          grant_id and locked status
// A granted requester keeps the transmitter until it sends a byte flagged last,
// or until it stalls LOCK_TIMEOUT cycles in HOLD (0 disables the timeout).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_tx_arbiter_if.slave bus
);

    localparam int RW = rr_w(NREQ);
    localparam int TW = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT + 1);

    state_t            state;
    logic [RW-1:0]     grant;
    logic [BYTE_W-1:0] data_q;
    logic              wr_q;
    logic              locked_q;
    logic [TW-1:0]     tmo;
    logic [TW-1:0]     tmo_next;
    logic              tmo_hit;

    logic              pick_any;
    logic [RW-1:0]     pick_idx;

    logic              cur_valid;
    logic              cur_last;
    logic [BYTE_W-1:0] cur_data;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req  (bus.req_valid),
        .last (grant),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // Mux out the granted requester's offer.
    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant == RW'(k)) begin
                cur_valid = bus.req_valid[k];
                cur_last  = bus.req_last[k];
                cur_data  = bus.req_data[k*BYTE_W +: BYTE_W];
            end
        end
    end

    assign tmo_next = tmo + 1'b1;
    assign tmo_hit  = (LOCK_TIMEOUT != 0) && (tmo_next == TW'(LOCK_TIMEOUT));

    // Acceptance is decoded from state so the pulse lines up with the capture edge.
    always_comb begin
        bus.req_ready = '0;
        if (state == ST_CAPTURE) begin
            bus.req_ready[grant] = 1'b1;
        end
    end

    assign bus.tx_wr    = wr_q;
    assign bus.tx_data  = data_q;
    assign bus.grant_id = grant;
    assign bus.locked   = locked_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            grant    <= RW'(NREQ - 1);
            data_q   <= 8'hFF;
            wr_q     <= 1'b0;
            locked_q <= 1'b0;
            tmo      <= '0;
        end else begin
            wr_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A frame may still be in flight after reset; never strobe over it.
                    if (pick_any && !bus.tx_busy) begin
                        grant <= pick_idx;
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    data_q   <= cur_data;
                    locked_q <= !cur_last;
                    wr_q     <= 1'b1;
                    state    <= ST_STROBE;
                end
                ST_STROBE: begin
                    state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!bus.tx_busy) begin
                        state <= locked_q ? ST_HOLD : ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (cur_valid) begin
                        tmo   <= '0;
                        state <= ST_CAPTURE;
                    end else if (tmo_hit) begin
                        tmo      <= '0;
                        locked_q <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (LOCK_TIMEOUT != 0) begin
                        tmo <= tmo_next;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
